// File: rtl/mdio_receiver.sv
// MDIO management-frame target: decodes 32-bit clause-22 frames sampled on mdc
// rising edges, raising register write/read strobes and returning read data.
module mdio_receiver #(
   parameter logic [4:0] PHY_ADDR = 5'h01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_out,
   input  logic        mdio_oe,
   output logic        mdio_in,
   output logic [4:0]  addr,
   output logic [15:0] wr_data,
   output logic        wr_stb,
   output logic        rd_stb,
   input  logic [15:0] rd_data,
   output logic        mdio_done
);

   localparam int unsigned CNT_W  = 5;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      TA     = 3'd2,
      WDATA  = 3'd3,
      RDATA  = 3'd4,
      DRAIN  = 3'd5
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [DATA_W-1:0]  sh, sh_nxt;
   logic [DATA_W-1:0]  rsh, rsh_nxt;
   logic [DATA_W-1:0]  sh_in;
   logic               op_rd, op_rd_nxt;
   logic               mdc_q;
   logic               rise;
   logic               mdio_in_nxt;
   logic [4:0]         addr_nxt;
   logic [DATA_W-1:0]  wr_data_nxt;
   logic               wr_stb_nxt, rd_stb_nxt, done_nxt;

   assign rise  = mdc & ~mdc_q;
   assign sh_in = {sh[DATA_W-2:0], mdio_out};

   // State and datapath register
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         rsh       <= '0;
         op_rd     <= 1'b0;
         mdc_q     <= 1'b0;
         mdio_in   <= 1'b0;
         addr      <= '0;
         wr_data   <= '0;
         wr_stb    <= 1'b0;
         rd_stb    <= 1'b0;
         mdio_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         sh        <= sh_nxt;
         rsh       <= rsh_nxt;
         op_rd     <= op_rd_nxt;
         mdc_q     <= mdc;
         mdio_in   <= mdio_in_nxt;
         addr      <= addr_nxt;
         wr_data   <= wr_data_nxt;
         wr_stb    <= wr_stb_nxt;
         rd_stb    <= rd_stb_nxt;
         mdio_done <= done_nxt;
      end
   end

   // Frame decode: every bit action is gated by an mdc rising edge
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sh_nxt      = sh;
      rsh_nxt     = rsh;
      op_rd_nxt   = op_rd;
      mdio_in_nxt = 1'b0;
      addr_nxt    = addr;
      wr_data_nxt = wr_data;
      wr_stb_nxt  = 1'b0;
      rd_stb_nxt  = 1'b0;
      done_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (rise && mdio_oe) begin
               sh_nxt    = {{(DATA_W-1){1'b0}}, mdio_out};
               cnt_nxt   = CNT_W'(1);
               state_nxt = HEADER;
            end
         end

         HEADER: begin
            if (rise) begin
               if (!mdio_oe) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  sh_nxt  = sh_in;
                  cnt_nxt = cnt + CNT_W'(1);
                  if (cnt == CNT_W'(3)) begin
                     // sh_in[3:2] = ST, sh_in[1:0] = OP
                     if (sh_in[3:2] != 2'b01 ||
                         (sh_in[1:0] != 2'b01 && sh_in[1:0] != 2'b10))
                        state_nxt = DRAIN;
                  end else if (cnt == CNT_W'(13)) begin
                     if (sh_in[9:5] != PHY_ADDR) begin
                        state_nxt = DRAIN;
                     end else begin
                        addr_nxt   = sh_in[4:0];
                        op_rd_nxt  = (sh_in[11:10] == 2'b10);
                        rd_stb_nxt = (sh_in[11:10] == 2'b10);
                        state_nxt  = TA;
                     end
                  end
               end
            end
         end

         TA: begin
            if (rise) begin
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(15)) begin
                  if (op_rd) begin
                     rsh_nxt     = rd_data;
                     mdio_in_nxt = rd_data[DATA_W-1];
                     state_nxt   = RDATA;
                  end else begin
                     state_nxt = WDATA;
                  end
               end
            end
         end

         WDATA: begin
            if (rise) begin
               if (!mdio_oe) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else if (cnt == CNT_W'(31)) begin
                  wr_data_nxt = sh_in;
                  wr_stb_nxt  = 1'b1;
                  done_nxt    = 1'b1;
                  cnt_nxt     = '0;
                  state_nxt   = IDLE;
               end else begin
                  sh_nxt  = sh_in;
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end

         RDATA: begin
            mdio_in_nxt = mdio_in;
            if (rise) begin
               if (cnt == CNT_W'(31)) begin
                  mdio_in_nxt = 1'b0;
                  done_nxt    = 1'b1;
                  cnt_nxt     = '0;
                  state_nxt   = IDLE;
               end else begin
                  rsh_nxt     = {rsh[DATA_W-2:0], 1'b0};
                  mdio_in_nxt = rsh[DATA_W-2];
                  cnt_nxt     = cnt + CNT_W'(1);
               end
            end
         end

         DRAIN: begin
            if (rise && !mdio_oe) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end

         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
